// File: rtl/gcd_pkg.sv
// Shared types and default sizing for the gcd_stream engine.
package gcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/gcd_datapath.sv
// Subtractive-Euclid datapath: operand registers, subtractors, comparators
// and the registered result/zero flag, all driven by strobes from the FSM.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             sub_a,
  input  logic             sub_b,
  input  logic             res_load,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             eq,
  output logic             lt,
  output logic             a_zero,
  output logic             b_zero,
  output logic [WIDTH-1:0] result,
  output logic             zero_err
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  assign eq     = (a_q == b_q);
  assign lt     = (a_q < b_q);
  assign a_zero = (a_q == '0);
  assign b_zero = (b_q == '0);

  // The larger operand is always the minuend, so the subtraction cannot wrap.
  // A|B covers both terminations: one operand zero, or both equal.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result   <= '0;
      zero_err <= 1'b0;
    end else begin
      if (load) begin
        a_q <= a_in;
        b_q <= b_in;
      end else if (sub_a) begin
        a_q <= a_q - b_q;
      end else if (sub_b) begin
        b_q <= b_q - a_q;
      end
      if (res_load) begin
        result   <= a_q | b_q;
        zero_err <= a_zero & b_zero;
      end
    end
  end

endmodule

// File: rtl/gcd_stream.sv
// Streaming GCD engine with valid/ready handshakes on both sides.
// Optional GCD_STEP_CNT_EN adds a saturating CALC-cycle counter on port steps.
module gcd_stream
  import gcd_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
`ifdef GCD_STEP_CNT_EN
  ,
  parameter int CNT_W = DEF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic             zero_err
`ifdef GCD_STEP_CNT_EN
  ,
  output logic [CNT_W-1:0] steps
`endif
);

  state_t state;
  state_t state_next;
  logic   accept;
  logic   load;
  logic   sub_a;
  logic   sub_b;
  logic   res_load;
  logic   eq;
  logic   lt;
  logic   a_zero;
  logic   b_zero;

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    sub_a      = 1'b0;
    sub_b      = 1'b0;
    res_load   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          load       = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (a_zero || b_zero || eq) begin
          res_load   = 1'b1;
          state_next = DONE;
        end else if (lt) begin
          sub_b = 1'b1;
        end else begin
          sub_a = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  gcd_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .sub_a   (sub_a),
    .sub_b   (sub_b),
    .res_load(res_load),
    .a_in    (a_in),
    .b_in    (b_in),
    .eq      (eq),
    .lt      (lt),
    .a_zero  (a_zero),
    .b_zero  (b_zero),
    .result  (gcd_out),
    .zero_err(zero_err)
  );

`ifdef GCD_STEP_CNT_EN
  // Counts every CALC cycle including the terminating one; frozen in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      steps <= '0;
    end else if (accept) begin
      steps <= '0;
    end else if (state == CALC && steps != '1) begin
      steps <= steps + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gcd_stream.sv
// Directed and randomized bench for gcd_stream (WIDTH=8); covers the
// GCD_STEP_CNT_EN counter when the macro is defined.
module tb_gcd_stream;

  localparam int W     = 8;
  localparam int CNT_W = 16;
  localparam int LIMIT = 300;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] gcd_out;
  logic         zero_err;
`ifdef GCD_STEP_CNT_EN
  logic [CNT_W-1:0] steps;
`endif

  int errors = 0;
  int checks = 0;

  gcd_stream #(
    .WIDTH(W)
`ifdef GCD_STEP_CNT_EN
    ,
    .CNT_W(CNT_W)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .b_in     (b_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .gcd_out  (gcd_out),
    .zero_err (zero_err)
`ifdef GCD_STEP_CNT_EN
    ,
    .steps    (steps)
`endif
  );

  always #5 clk = ~clk;

  // Drives one transaction and records what it observed; comparisons happen
  // in the calling test. lat counts edges from accept (inclusive) to out_valid.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int stall, input bit early,
                       output logic [W-1:0] g, output logic z, output int lat,
                       output logic [CNT_W-1:0] st, output logic done_ok,
                       output logic rdy_after);
    int cnt;
    @(negedge clk);
    a_in = a; b_in = b; in_valid = 1'b1; out_ready = early;
    cnt = 0;
    while (!in_ready && cnt < LIMIT) begin
      @(negedge clk);
      cnt++;
    end
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!out_valid && lat < LIMIT) begin
      @(negedge clk);
      lat++;
    end
    done_ok = out_valid;
    g = gcd_out;
    z = zero_err;
`ifdef GCD_STEP_CNT_EN
    st = steps;
`else
    st = '0;
`endif
    rdy_after = 1'b0;
    if (done_ok) begin
      repeat (early ? 0 : stall) @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      rdy_after = in_ready && !out_valid;
    end else begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (gcd_out !== '0 || zero_err !== 1'b0) begin
      errors++; $display("FAIL reset_result: got gcd=%0d zero_err=%b want 0/0", gcd_out, zero_err);
    end
`ifdef GCD_STEP_CNT_EN
    checks++;
    if (steps !== '0) begin
      errors++; $display("FAIL reset_steps: got %0d want 0", steps);
    end
`endif
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_vectors;
    logic [W-1:0] va[10] = '{8'd12, 8'd9, 8'd17, 8'd255, 8'd1, 8'd0, 8'd6, 8'd0, 8'd30, 8'd21};
    logic [W-1:0] vb[10] = '{8'd8, 8'd9, 8'd5, 8'd1, 8'd255, 8'd6, 8'd0, 8'd0, 8'd12, 8'd14};
    logic [W-1:0] vg[10] = '{8'd4, 8'd9, 8'd1, 8'd1, 8'd1, 8'd6, 8'd6, 8'd0, 8'd6, 8'd7};
    logic         vz[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int           vn[10] = '{3, 1, 7, 255, 255, 1, 1, 1, 4, 3};
    logic [W-1:0] g;
    logic [CNT_W-1:0] st;
    logic z, ok, rdy;
    int lat;
    for (int i = 0; i < 10; i++) begin
      do_op(va[i], vb[i], i % 3, 1'b0, g, z, lat, st, ok, rdy);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL vec%0d_timeout: no out_valid after %0d edges", i, lat);
        continue;
      end
      checks++;
      if (g !== vg[i] || z !== vz[i]) begin
        errors++;
        $display("FAIL vec%0d_result (%0d,%0d): got gcd=%0d zero_err=%b want gcd=%0d zero_err=%b",
                 i, va[i], vb[i], g, z, vg[i], vz[i]);
      end
      checks++;
      if (lat != vn[i] + 1) begin
        errors++; $display("FAIL vec%0d_latency: got %0d edges want %0d", i, lat, vn[i] + 1);
      end
`ifdef GCD_STEP_CNT_EN
      checks++;
      if (st !== CNT_W'(vn[i])) begin
        errors++; $display("FAIL vec%0d_steps: got %0d want %0d", i, st, vn[i]);
      end
`endif
      checks++;
      if (rdy !== 1'b1) begin
        errors++; $display("FAIL vec%0d_idle_after: in_ready/out_valid not back to idle (got %b)", i, rdy);
      end
    end
  endtask

  task automatic test_out_ready_early;
    logic [W-1:0] g;
    logic [CNT_W-1:0] st;
    logic z, ok, rdy;
    int lat;
    do_op(8'd12, 8'd8, 0, 1'b1, g, z, lat, st, ok, rdy);
    checks++;
    if (!ok || g !== 8'd4 || lat != 4) begin
      errors++; $display("FAIL early_ready: got ok=%b gcd=%0d lat=%0d want 1/4/4", ok, g, lat);
    end
    checks++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL early_ready_idle: got %b want 1", rdy);
    end
  endtask

  task automatic test_back_pressure;
    int cnt;
    logic [W-1:0] g;
    logic [CNT_W-1:0] st;
    logic z, ok, rdy;
    int lat;
    @(negedge clk);
    a_in = 8'd12; b_in = 8'd8; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < LIMIT) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_timeout: out_valid=%b want 1", out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1 || gcd_out !== 8'd4 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: got out_valid=%b gcd=%0d in_ready=%b want 1/4/0",
                 i, out_valid, gcd_out, in_ready);
      end
      if (i == 2) begin
        a_in = 8'd9; b_in = 8'd3; in_valid = 1'b1;
      end
      if (i == 6) in_valid = 1'b0;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    do_op(8'd30, 8'd12, 0, 1'b0, g, z, lat, st, ok, rdy);
    checks++;
    if (!ok || g !== 8'd6 || lat != 5) begin
      errors++; $display("FAIL bp_next_op: got ok=%b gcd=%0d lat=%0d want 1/6/5", ok, g, lat);
    end
  endtask

  task automatic test_reset_mid_calc;
    logic [W-1:0] g;
    logic [CNT_W-1:0] st;
    logic z, ok, rdy;
    int lat;
    @(negedge clk);
    a_in = 8'd200; b_in = 8'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || gcd_out !== '0) begin
      errors++;
      $display("FAIL midrst_during: got out_valid=%b in_ready=%b gcd=%0d want 0/0/0",
               out_valid, in_ready, gcd_out);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL midrst_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    do_op(8'd21, 8'd14, 1, 1'b0, g, z, lat, st, ok, rdy);
    checks++;
    if (!ok || g !== 8'd7 || z !== 1'b0 || lat != 4) begin
      errors++; $display("FAIL midrst_next_op: got ok=%b gcd=%0d zero_err=%b lat=%0d want 1/7/0/4", ok, g, z, lat);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, g, x, y, t;
    logic [CNT_W-1:0] st;
    logic z, ok, rdy;
    int lat, n;
    for (int i = 0; i < 1000; i++) begin
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) a = '0;
      if ($urandom_range(0, 19) == 0) b = '0;
      x = a; y = b;
      while (y != 0) begin
        t = x % y; x = y; y = t;
      end
      n = 1;
      if (a != 0 && b != 0) n = a / b + b / a + 2 * ((a > b) ? 0 : 0);
      // subtractive count: walk the Euclid quotients
      begin
        int p, q, r;
        p = a; q = b; n = 1;
        while (p != 0 && q != 0 && p != q) begin
          if (p > q) begin
            r = (p - 1) / q; n += r; p -= r * q;
          end else begin
            r = (q - 1) / p; n += r; q -= r * p;
          end
        end
      end
      do_op(a, b, $urandom_range(0, 3), 1'b0, g, z, lat, st, ok, rdy);
      checks++;
      if (!ok || g !== x || z !== (a == 0 && b == 0) || lat != n + 1) begin
        errors++;
        $display("FAIL rand%0d (%0d,%0d): got ok=%b gcd=%0d zero_err=%b lat=%0d want gcd=%0d zero_err=%b lat=%0d",
                 i, a, b, ok, g, z, lat, x, (a == 0 && b == 0), n + 1);
      end
`ifdef GCD_STEP_CNT_EN
      checks++;
      if (st !== CNT_W'(n)) begin
        errors++; $display("FAIL rand%0d_steps: got %0d want %0d", i, st, n);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_out_ready_early();
    test_back_pressure();
    test_reset_mid_calc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gcd_stream.md
Name: gcd_stream

Overview:
Parametrised, self-contained GCD engine: a subtractive-Euclid datapath plus its own control FSM, behind valid/ready handshakes on input and output. Generalises the fixed 4-bit datapath/controller pair to WIDTH bits. Adds zero-operand handling, back-pressure on the result, and an error flag. Sits between an operand producer and a result consumer in the arithmetic subsystem.

Parameters:
WIDTH, 8, operand/result width in bits (>= 2)
CNT_W, 16, width of optional step counter; saturates, must be able to hold 2^WIDTH-1 for exact counts

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operand pair valid
in_ready  output  1  engine can accept operands
a_in  input  WIDTH  operand A
b_in  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
gcd_out  output  WIDTH  GCD result
zero_err  output  1  both operands were 0; qualified by out_valid
steps  output  CNT_W  CALC cycles used; only with GCD_STEP_CNT_EN

Behaviour:
- Single clock clk; rst is synchronous and active-high; all state updates on the rising edge of clk.
- Reset: state IDLE, A/B/result registers 0, out_valid=0, zero_err=0, steps=0. in_ready is forced to 0 while rst is high.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, load A<=a_in, B<=b_in, go CALC. Otherwise hold.
- CALC: one decision per cycle, priority order:
  - A==0 or B==0: result<=A|B; zero_err<=(A==0&&B==0); go DONE.
  - A==B: result<=A; go DONE.
  - A>B: A<=A-B.
  - A<B: B<=B-A.
  - Subtraction is WIDTH bits and unsigned; it never underflows because the larger operand is always the minuend.
- DONE: out_valid=1; gcd_out, zero_err and steps held stable. On out_valid&&out_ready, go IDLE and drop out_valid the next cycle. in_ready=0 in CALC and DONE; no overlap of accept and deliver.
- Latency, accept edge to out_valid high: N+1 edges, where N = number of CALC cycles (subtractions + 1 terminating cycle). Examples: (12,8) gives N=3; (x,x) gives N=1; (0,x) gives N=1.
- Worst case: (2^WIDTH-1, 1) gives N=2^WIDTH-1.
- gcd_out and zero_err are registered, not combinational; values outside DONE are don't-care to consumers, but held at last result.
- Reset mid-operation (CALC or DONE): abort, return to IDLE, discard the result, out_valid=0 on the following cycle.
- in_valid while busy: ignored (not captured). The producer must hold its operands until in_ready.
- out_ready high before DONE: no effect.

Optional Feature:
Macro GCD_STEP_CNT_EN.
- Defined: steps port and counter exist. The counter clears on accept and increments once per CALC cycle, including the terminating cycle; it saturates at 2^CNT_W-1 and holds through DONE. On completion, steps=N.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- Package gcd_pkg: state enum (IDLE, CALC, DONE) and default WIDTH/CNT_W constants.
- One natural sub-module, gcd_datapath: the A/B/result registers, subtractors and comparators (eq, lt, a_zero, b_zero). It is driven by load/select strobes from the FSM in gcd_stream.

Test Plan:
- Basic: a=12, b=8, out_ready=1 -> gcd_out=4, zero_err=0, out_valid 4 edges after accept; steps=3 if enabled.
- Equal/coprime/worst case (WIDTH=8): (9,9) -> 9 with N=1; (17,5) -> 1; (255,1) -> 1 with N=255; (1,255) -> 1.
- Zeros: (0,6) -> 6, zero_err=0; (6,0) -> 6; (0,0) -> 0, zero_err=1. Each with N=1.
- Back-pressure: hold out_ready=0 for 10 cycles -> out_valid, gcd_out stay stable and in_ready=0; a new in_valid during this time is not captured. Release -> handshake, IDLE, in_ready=1 next cycle.
- Reset mid-CALC: start (200,3), assert rst for 1 cycle in step 5 -> out_valid=0, in_ready=1 after release; a following (21,14) -> 7.
- Random: 1000 random pairs with random out_ready stalls, checked against a reference-model gcd; WIDTH=4 and WIDTH=16 builds, macro on and off.
